// File: rtl/uart_rx_byte_capture.sv
// uart_rx_byte_capture
//   8N1 UART receiver. Deserialises the asynchronous rx line into bytes and
//   holds the last correctly framed byte for the two hex display digits.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx         raw serial line, idles high, asynchronous to clk
//   rx_data    last correctly framed byte
//   rx_valid   one-cycle pulse when rx_data updates
//   frame_err  one-cycle pulse when the stop bit samples low
//   busy       high whenever the receiver is not idle
//   hex_hi     rx_data[7:4] for the upper display digit
//   hex_lo     rx_data[3:0] for the lower display digit
module uart_rx_byte_capture #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [3:0] hex_hi,
    output logic [3:0] hex_lo
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        RECOVER
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    data_n;
    logic          valid_n, ferr_n;
    logic          rx_meta, rx_s;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shift     <= shift_n;
            rx_data   <= data_n;
            rx_valid  <= valid_n;
            frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        data_n  = rx_data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                // Recheck the line at mid start-bit to reject short glitches.
                if (cnt == CNT_HALF) begin
                    if (!rx_s) begin
                        state_n = DATA;
                        cnt_n   = '0;
                        idx_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n        = '0;
                    shift_n[idx] = rx_s;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                // Leaving mid stop-bit lets a start bit follow with no gap.
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = RECOVER;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            RECOVER: begin
                // A held-low break must not be mistaken for a new start bit.
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy   = (state != IDLE);
    assign hex_hi = rx_data[7:4];
    assign hex_lo = rx_data[3:0];

endmodule

// File: tb/tb_uart_rx_byte_capture.sv
module tb_uart_rx_byte_capture;

    localparam int CPB = 16;
    // Falling edge of start bit to visible rx_valid/frame_err.
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;
    localparam int TOL = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
    logic [3:0] hex_hi;
    logic [3:0] hex_lo;

    uart_rx_byte_capture #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy),
        .hex_hi    (hex_hi),
        .hex_lo    (hex_lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] b;
        int         t;
    } ev_t;

    ev_t        exp_q[$];   // expected good frames
    int         ferr_q[$];  // expected frame_err times
    int         vtimes[$];  // observed rx_valid times
    int         n_valid = 0;
    int         n_ferr  = 0;
    logic [7:0] model_held = 8'h00;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic chk_tol(input string n, input int a, input int e, input int tol);
        tests++;
        if (a < e - tol || a > e + tol) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d +/- %0d", n, a, e, tol);
        end
    endtask

    task automatic fail_now(input string n, input int a, input int e);
        tests++;
        fails++;
        $display("FAIL %s: got %0d, want %0d (cycle %0d)", n, a, e, cyc);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller is 1 time unit after a rising edge. Each bit lasts exactly CPB clocks.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        ev_t e;
        rx = 1'b0;
        if (stop) begin
            e.b = b;
            e.t = cyc + LAT;
            exp_q.push_back(e);
        end else begin
            ferr_q.push_back(cyc + LAT);
        end
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(CPB);
        end
        rx = stop;
        wait_cycles(CPB);
    endtask

    // Compare process: DUT versus frame-level model on every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_held = 8'h00;
            chk("reset_outputs", {rx_data, hex_hi, hex_lo, rx_valid, frame_err, busy}, '0);
        end else begin
            chk("valid_ferr_exclusive", {31'd0, rx_valid & frame_err}, 0);
            if (rx_valid) begin
                n_valid++;
                vtimes.push_back(cyc);
                if (exp_q.size() == 0) begin
                    fail_now("spurious_valid", 1, 0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk_tol("valid_time", cyc, e.t, TOL);
                    model_held = e.b;
                end
            end
            if (frame_err) begin
                n_ferr++;
                if (ferr_q.size() == 0) begin
                    fail_now("spurious_frame_err", 1, 0);
                end else begin
                    int t;
                    t = ferr_q.pop_front();
                    chk_tol("ferr_time", cyc, t, TOL);
                end
            end
            if (exp_q.size() > 0 && cyc > exp_q[0].t + TOL) begin
                fail_now("missing_valid", cyc, exp_q[0].t);
                void'(exp_q.pop_front());
            end
            if (ferr_q.size() > 0 && cyc > ferr_q[0] + TOL) begin
                fail_now("missing_frame_err", cyc, ferr_q[0]);
                void'(ferr_q.pop_front());
            end
            chk("rx_data_held", {24'd0, rx_data}, {24'd0, model_held});
            chk("hex_held", {24'd0, hex_hi, hex_lo}, {24'd0, model_held});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        wait_cycles(4);
        chk("reset_rx_data", {24'd0, rx_data}, 32'h00);
        chk("reset_busy", {31'd0, busy}, 0);
        rst_n = 1'b1;
        wait_cycles(8);

        // 1: single frame
        send_frame(8'h5A, 1'b1);
        wait_cycles(CPB);
        chk("t1_rx_data", {24'd0, rx_data}, 32'h5A);
        chk("t1_hex_hi", {28'd0, hex_hi}, 32'h5);
        chk("t1_hex_lo", {28'd0, hex_lo}, 32'hA);
        chk("t1_busy_idle", {31'd0, busy}, 0);
        chk("t1_nvalid", n_valid, 1);

        // 2: back-to-back, no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'hA5, 1'b1);
        wait_cycles(CPB);
        chk("t2_nvalid", n_valid, 4);
        if (vtimes.size() >= 4) begin
            chk_tol("t2_spacing_a", vtimes[2] - vtimes[1], 160, TOL);
            chk_tol("t2_spacing_b", vtimes[3] - vtimes[2], 160, TOL);
        end else begin
            fail_now("t2_vtimes", vtimes.size(), 4);
        end
        chk("t2_rx_data", {24'd0, rx_data}, 32'hA5);

        // 3: short low glitch
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(40);
        chk("t3_nvalid", n_valid, 4);
        chk("t3_nferr", n_ferr, 0);
        chk("t3_rx_data", {24'd0, rx_data}, 32'hA5);
        chk("t3_busy", {31'd0, busy}, 0);

        // 4: bad stop bit followed by a long break
        send_frame(8'h3C, 1'b0);
        wait_cycles(40 * CPB);
        chk("t4_nferr", n_ferr, 1);
        chk("t4_nvalid", n_valid, 4);
        chk("t4_hex_hi", {28'd0, hex_hi}, 32'hA);
        chk("t4_hex_lo", {28'd0, hex_lo}, 32'h5);
        rx = 1'b1;
        wait_cycles(2 * CPB);
        chk("t4_busy_after_break", {31'd0, busy}, 0);
        send_frame(8'h11, 1'b1);
        wait_cycles(CPB);
        chk("t4_rx_data", {24'd0, rx_data}, 32'h11);

        // 5: reset during data bit 4 of 0x77
        begin
            logic [7:0] b;
            b  = 8'h77;
            rx = 1'b0;
            wait_cycles(CPB);
            for (int i = 0; i < 4; i++) begin
                rx = b[i];
                wait_cycles(CPB);
            end
            rx = b[4];
            wait_cycles(CPB / 2);
            chk("t5_busy_mid", {31'd0, busy}, 1);
            rst_n = 1'b0;
            #1;
            chk("t5_reset_outs", {rx_data, hex_hi, hex_lo, rx_valid, frame_err, busy}, '0);
            wait_cycles(3);
            rx = 1'b1;
            wait_cycles(3);
            rst_n = 1'b1;
            wait_cycles(2 * CPB);
        end
        send_frame(8'h81, 1'b1);
        wait_cycles(CPB);
        chk("t5_rx_data", {24'd0, rx_data}, 32'h81);
        chk("t5_hex_hi", {28'd0, hex_hi}, 32'h8);
        chk("t5_hex_lo", {28'd0, hex_lo}, 32'h1);
        chk("t5_nvalid", n_valid, 6);
        chk("pending_events", exp_q.size() + ferr_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte_capture.md
Name: uart_rx_byte_capture

Overview:
- 8N1 UART receiver that deserialises the asynchronous serial line into bytes.
- Holds the last good byte as two nibble registers that drive the two hex-to-7-segment decoders on the receive-side display.
- Sits between the board RX pin and the display decoders. It also presents a byte/valid pulse for other consumers.

Parameters:
- CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200). Must be at least 4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  raw serial line; idles high; asynchronous to clk.
- rx_data  output  8  last correctly framed byte.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- busy  output  1  high whenever the FSM is not in IDLE.
- hex_hi  output  4  rx_data[7:4], held for display.
- hex_lo  output  4  rx_data[3:0], held for display.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE; counters and shift register 0.
  - Both synchroniser flops 1.
  - rx_data, hex_hi and hex_lo are 0, so the display shows "00".
  - rx_valid, frame_err and busy are 0.
- Reset mid-frame aborts the frame with no pulse. Release of reset is synchronous to clk.
- Synchroniser: rx passes through 2 flops (rx_s). The FSM only ever looks at rx_s.
- Bit counter runs 0..CLKS_PER_BIT-1. Bit index counts 0..7.
- FSM states and transitions:
  - IDLE: when rx_s is 0, go to START and clear the counter.
  - START: count to CLKS_PER_BIT/2-1 (integer division), which is mid start-bit.
    - If rx_s is 0 there, go to DATA and clear the counter and bit index.
    - If rx_s is 1 (glitch), return to IDLE. No pulse.
  - DATA: count to CLKS_PER_BIT-1, then sample rx_s into shift bit[index]. Order is LSB first.
    - After index 7, go to STOP. Otherwise increment the index.
  - STOP: count to CLKS_PER_BIT-1, then sample rx_s.
    - If 1: on the next edge, rx_data and {hex_hi,hex_lo} are loaded with the shift register, rx_valid pulses for 1 cycle, and the FSM goes to IDLE.
    - If 0: frame_err pulses for 1 cycle, rx_data, hex_hi and hex_lo are unchanged, and the FSM goes to RECOVER.
  - RECOVER: wait until rx_s is 1, then go to IDLE. A break condition (line held low) therefore never re-triggers START.
- Timing:
  - All samples land mid-bit. The start-to-stop sampling pitch is exactly CLKS_PER_BIT.
  - rx_valid pulses about (2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1) clocks after the rx falling edge. Bench tolerance is ±2 clocks.
- Back-to-back frames: IDLE is reached mid stop-bit, so a start bit arriving right after the stop bit is accepted. No idle gap is required.
- rx_valid and frame_err are never high in the same cycle.
- hex_hi and hex_lo hold indefinitely between frames.
- busy is high from the cycle after the START entry edge until the cycle IDLE is re-entered.

Test Plan:
(CLKS_PER_BIT = 16 for simulation)
1. Reset, then send a frame of 0x5A -> one rx_valid pulse; rx_data=0x5A, hex_hi=5, hex_lo=A; frame_err never asserts; busy returns to 0.
2. Send 0x00, 0xFF and 0xA5 back-to-back with no idle gap -> three rx_valid pulses, each spaced 10*16 clocks ±2; final rx_data=0xA5.
3. Drive a 4-clock low glitch on the idle line -> FSM returns to IDLE; no rx_valid, no frame_err; rx_data unchanged at prior 0xA5.
4. Send 0x3C with stop bit low, then hold the line low for 40 bit times, then release -> one frame_err pulse; no rx_valid; hex_hi=A and hex_lo=5 unchanged; no spurious frame during the break; next frame 0x11 is received correctly.
5. Assert rst_n low at data bit 4 of frame 0x77 -> all outputs 0 immediately (hex "00"); after release, a fresh frame 0x81 is captured correctly (hex_hi=8, hex_lo=1).
